// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 data-bus interface.
//   dbus_state_e  : FSM state encoding (IDLE, ACCESS, DONE)
//   SZ_*          : access size codes as driven on size_in (11 is also a word)
//   is_misaligned : true for a half access on an odd address, or a word
//                   access on a non-word-aligned address
package msrv32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } dbus_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] a10);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF) mis = a10[0];
    else if (size[1])    mis = (a10 != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/msrv32_store_align.sv
// Combinational store-data alignment.
//   size_in   [1:0]  : SZ_BYTE / SZ_HALF / word (10 or 11)
//   addr_in   [1:0]  : low address bits
//   wdata_in  [31:0] : LSB-justified store data
//   data_out  [31:0] : store data replicated into every lane
//   mask_out  [3:0]  : byte enables for the addressed lanes
module msrv32_store_align
  import msrv32_pkg::*;
(
  input  logic [1:0]  size_in,
  input  logic [1:0]  addr_in,
  input  logic [31:0] wdata_in,
  output logic [31:0] data_out,
  output logic [3:0]  mask_out
);

  always_comb begin
    data_out = wdata_in;
    mask_out = 4'b1111;
    case (size_in)
      SZ_BYTE: begin
        data_out = {4{wdata_in[7:0]}};
        mask_out = 4'b0001 << addr_in;
      end
      SZ_HALF: begin
        data_out = {2{wdata_in[15:0]}};
        mask_out = 4'b0011 << {addr_in[1], 1'b0};
      end
      default: begin
        data_out = wdata_in;
        mask_out = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/msrv32_dbus_if.sv
// Data-bus interface between the msrv32 pipeline and a ready/response bus.
// Accepts one load/store at a time, drives the bus until ready or timeout,
// then pulses lu_valid_out for one cycle with err_out qualifying it.
//   Pipeline side : mem_req_in, mem_we_in, size_in, unsigned_in, addr_in,
//                   wdata_in -> busy_out
//   Bus side      : ms_d_req_out, ms_d_we_out, ms_d_addr_out, ms_d_data_out,
//                   ms_d_wr_en_out <- ms_d_ready_in, ms_d_rdata_in, ahb_resp_in
//   Load unit     : load_size_out, load_unsigned_out, iadder_1_to_0_out,
//                   lu_data_out, lu_valid_out, err_out, misaligned_out
// Parameter WAIT_LIMIT: ACCESS cycles allowed without ready before timeout.
// Macro MSRV32_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus
// and complete immediately with err_out and misaligned_out set.
module msrv32_dbus_if
  import msrv32_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        mem_req_in,
  input  logic        mem_we_in,
  input  logic [1:0]  size_in,
  input  logic        unsigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        busy_out,
  output logic        ms_d_req_out,
  output logic        ms_d_we_out,
  output logic [31:0] ms_d_addr_out,
  output logic [31:0] ms_d_data_out,
  output logic [3:0]  ms_d_wr_en_out,
  input  logic        ms_d_ready_in,
  input  logic [31:0] ms_d_rdata_in,
  input  logic        ahb_resp_in,
  output logic [1:0]  load_size_out,
  output logic        load_unsigned_out,
  output logic [1:0]  iadder_1_to_0_out,
  output logic [31:0] lu_data_out,
  output logic        lu_valid_out,
  output logic        err_out,
  output logic        misaligned_out
);

  localparam int unsigned CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

  dbus_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    mask_q, mask_d;
  logic          err_q, err_d;
  logic [31:0]   lu_q, lu_d;
  logic [31:0]   al_data;
  logic [3:0]    al_mask;
`ifdef MSRV32_MISALIGN_TRAP_EN
  logic          mis_q, mis_d;
`endif

  msrv32_store_align u_align (
    .size_in  (size_in),
    .addr_in  (addr_in[1:0]),
    .wdata_in (wdata_in),
    .data_out (al_data),
    .mask_out (al_mask)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    err_d   = err_q;
    lu_d    = lu_q;
`ifdef MSRV32_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (mem_req_in) begin
          state_d = ST_ACCESS;
          cnt_d   = '0;
          we_d    = mem_we_in;
          size_d  = size_in;
          uns_d   = unsigned_in;
          addr_d  = addr_in;
          data_d  = al_data;
          mask_d  = mem_we_in ? al_mask : 4'b0000;
          err_d   = 1'b0;
`ifdef MSRV32_MISALIGN_TRAP_EN
          mis_d   = 1'b0;
          if (is_misaligned(size_in, addr_in[1:0])) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            mis_d   = 1'b1;
          end
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (ms_d_ready_in) begin
          state_d = ST_DONE;
          err_d   = ahb_resp_in;
          if (!we_q) lu_d = ms_d_rdata_in;
        end else if (cnt_q == LAST) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      lu_q    <= '0;
`ifdef MSRV32_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      lu_q    <= lu_d;
`ifdef MSRV32_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    busy_out          = (state_q == ST_ACCESS);
    ms_d_req_out      = (state_q == ST_ACCESS);
    ms_d_we_out       = (state_q == ST_ACCESS) && we_q;
    ms_d_addr_out     = {addr_q[31:2], 2'b00};
    ms_d_data_out     = data_q;
    ms_d_wr_en_out    = (state_q == ST_ACCESS) ? mask_q : 4'b0000;
    load_size_out     = size_q;
    load_unsigned_out = uns_q;
    iadder_1_to_0_out = addr_q[1:0];
    lu_data_out       = lu_q;
    lu_valid_out      = (state_q == ST_DONE);
    err_out           = (state_q == ST_DONE) && err_q;
`ifdef MSRV32_MISALIGN_TRAP_EN
    misaligned_out    = (state_q == ST_DONE) && mis_q;
`else
    misaligned_out    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_msrv32_dbus_if.sv
module tb_msrv32_dbus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0, mem_we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, req, we_o;
  logic [31:0] baddr, bdata;
  logic [3:0]  bmask;
  logic        ready = 1'b0, resp = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  lsize, a10;
  logic        luns, valid, err, mis;
  logic [31:0] lu_data;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic        err;
    logic        mis;
    logic [31:0] data;
    logic [1:0]  a10;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  msrv32_dbus_if #(.WAIT_LIMIT(16)) dut (
    .clk_in(clk), .rst_in(rst),
    .mem_req_in(mem_req), .mem_we_in(mem_we), .size_in(size),
    .unsigned_in(uns), .addr_in(addr), .wdata_in(wdata),
    .busy_out(busy), .ms_d_req_out(req), .ms_d_we_out(we_o),
    .ms_d_addr_out(baddr), .ms_d_data_out(bdata), .ms_d_wr_en_out(bmask),
    .ms_d_ready_in(ready), .ms_d_rdata_in(rdata), .ahb_resp_in(resp),
    .load_size_out(lsize), .load_unsigned_out(luns),
    .iadder_1_to_0_out(a10), .lu_data_out(lu_data),
    .lu_valid_out(valid), .err_out(err), .misaligned_out(mis)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: got valid=1 expected no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("err_out", {31'b0, err}, {31'b0, e.err});
        chk("misaligned_out", {31'b0, mis}, {31'b0, e.mis});
        chk("lu_data_out", lu_data, e.data);
        chk("iadder_1_to_0", {30'b0, a10}, {30'b0, e.a10});
      end
    end
  end

  // Called #1 after an edge with the DUT in IDLE or DONE; returns the accept edge.
  task automatic issue(input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d, output int e);
    mem_req = 1'b1; mem_we = w; size = s; uns = u; addr = a; wdata = d;
    @(posedge clk); #1;
    mem_req = 1'b0;
    e = cyc;
  endtask

  typedef struct {
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] xd;
    logic [3:0]  xm;
  } st_vec_t;
  st_vec_t stv[5] = '{
    '{2'b00, 32'h0000_1003, 32'h0000_00AB, 32'hABAB_ABAB, 4'b1000},
    '{2'b00, 32'h0000_0001, 32'h1234_5677, 32'h7777_7777, 4'b0010},
    '{2'b01, 32'h0000_0002, 32'hFFFF_5566, 32'h5566_5566, 4'b1100},
    '{2'b01, 32'h0000_0000, 32'h0000_A0B0, 32'hA0B0_A0B0, 4'b0011},
    '{2'b11, 32'h0000_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111}
  };

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int e2;
    logic [31:0] lu_model;
    lu_model = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_lu_data", lu_data, 0);
    chk("rst_addr", baddr, 0);

    // Stores, ready in the first ACCESS cycle.
    foreach (stv[i]) begin
      issue(1'b1, stv[i].s, 1'b0, stv[i].a, stv[i].d, e);
      chk("st_req", {31'b0, req}, 1);
      chk("st_we", {31'b0, we_o}, 1);
      chk("st_busy", {31'b0, busy}, 1);
      chk("st_addr", baddr, {stv[i].a[31:2], 2'b00});
      chk("st_data", bdata, stv[i].xd);
      chk("st_mask", {28'b0, bmask}, {28'b0, stv[i].xm});
      sbq.push_back('{1'b0, 1'b0, lu_model, stv[i].a[1:0], e + 1});
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      chk("st_done_req", {31'b0, req}, 0);
      chk("st_done_busy", {31'b0, busy}, 0);
    end

    // Half load, three wait cycles, stray request ignored while busy.
    issue(1'b0, 2'b01, 1'b0, 32'h0000_2002, '0, e);
    lu_model = 32'h8001_1234;
    sbq.push_back('{1'b0, 1'b0, lu_model, 2'b10, e + 4});
    chk("ld_mask", {28'b0, bmask}, 0);
    chk("ld_we", {31'b0, we_o}, 0);
    mem_req = 1'b1; addr = 32'h0000_7777;
    repeat (3) @(posedge clk);
    #1 mem_req = 1'b0;
    chk("ld_hold_addr", baddr, 32'h0000_2000);
    chk("ld_size", {30'b0, lsize}, 1);
    rdata = 32'h8001_1234; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; rdata = '0;
    chk("ld_done_a10", {30'b0, a10}, 2);

    // Timeout: ready never asserted.
    @(posedge clk); #1;
    issue(1'b0, 2'b00, 1'b1, 32'h0000_2001, '0, e);
    sbq.push_back('{1'b1, 1'b0, lu_model, 2'b01, e + 16});
    for (int i = 0; i < 40 && !valid; i++) begin
      @(posedge clk); #1;
    end
    chk("to_valid", {31'b0, valid}, 1);
    chk("to_req_in_done", {31'b0, req}, 0);
    @(posedge clk); #1;
    chk("to_req_after", {31'b0, req}, 0);

    // Bus error, then back-to-back request accepted from DONE.
    issue(1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'h1122_3344, e);
    sbq.push_back('{1'b1, 1'b0, lu_model, 2'b00, e + 1});
    ready = 1'b1; resp = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; resp = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_5000, '0, e2);
    chk("b2b_edge", e2, e + 2);
    chk("b2b_req", {31'b0, req}, 1);
    chk("b2b_addr", baddr, 32'h0000_5000);
    lu_model = 32'hCAFE_F00D;
    sbq.push_back('{1'b0, 1'b0, lu_model, 2'b00, e2 + 1});
    rdata = 32'hCAFE_F00D; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;

    // Reset in the second ACCESS cycle.
    issue(1'b1, 2'b10, 1'b1, 32'h0000_6004, 32'h5555_AAAA, e);
    @(posedge clk); #1;
    chk("rs_pre_req", {31'b0, req}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    lu_model = '0;
    chk("rs_req", {31'b0, req}, 0);
    chk("rs_valid", {31'b0, valid}, 0);
    chk("rs_lu_data", lu_data, 0);
    chk("rs_addr", baddr, 0);
    chk("rs_data", bdata, 0);
    chk("rs_attr", {28'b0, lsize, luns, err}, 0);
    repeat (2) @(posedge clk); #1;

    // Misaligned word load.
    rdata = 32'h0BAD_F00D;
`ifdef MSRV32_MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'h0000_3001, '0, e);
    sbq.push_back('{1'b1, 1'b1, lu_model, 2'b01, e});
    chk("mis_no_req", {31'b0, req}, 0);
    chk("mis_valid", {31'b0, valid}, 1);
    @(posedge clk); #1;
`else
    issue(1'b0, 2'b10, 1'b0, 32'h0000_3001, '0, e);
    chk("mis_req", {31'b0, req}, 1);
    chk("mis_addr", baddr, 32'h0000_3000);
    lu_model = 32'h0BAD_F00D;
    sbq.push_back('{1'b0, 1'b0, lu_model, 2'b01, e + 1});
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
`endif

    repeat (3) @(posedge clk); #1;
    chk("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/msrv32_dbus_if.md
MSRV32_DBUS_IF -- requirements
Module: msrv32_dbus_if

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 16: maximum cycles to wait for bus ready before a timeout error.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk_in  input  1  rising-edge clock.
REQ-004 rst_in  input  1  synchronous active-high reset.
REQ-005 mem_req_in  input  1  pipeline requests a load/store.
REQ-006 mem_we_in  input  1  1 = store, 0 = load.
REQ-007 size_in  input  2  00 byte, 01 half, 10/11 word.
REQ-008 unsigned_in  input  1  load zero-extend flag, passed through.
REQ-009 addr_in  input  32  byte address (iadder result).
REQ-010 wdata_in  input  32  store data, LSB-justified.
REQ-011 busy_out  output  1  stall to pipeline while a transfer is outstanding.
REQ-012 ms_d_req_out  output  1  bus request; ms_d_we_out  output  1  bus write.
REQ-013 ms_d_addr_out  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-014 ms_d_data_out  output  32  aligned store data; ms_d_wr_en_out  output  4  byte mask.
REQ-015 ms_d_ready_in  input  1  bus completes; ms_d_rdata_in  input  32; ahb_resp_in  input  1  bus error.
REQ-016 load_size_out 2, load_unsigned_out 1, iadder_1_to_0_out 2, lu_data_out 32: registered attributes and read data for the load unit.
REQ-017 lu_valid_out  output  1  one-cycle completion pulse; err_out  output  1  error qualifier of that pulse; misaligned_out  output  1.

Function
REQ-018 SHALL implement FSM IDLE, ACCESS, DONE.
REQ-019 IDLE or DONE with mem_req_in=1: latch request fields, wait counter to 0, go ACCESS.
REQ-020 DONE with mem_req_in=0 -> IDLE; back-to-back requests accepted from DONE with no bubble.
REQ-021 ACCESS: ms_d_req_out=1, ms_d_we_out=latched we; busy_out=1.
REQ-022 ACCESS with ms_d_ready_in=1: capture ms_d_rdata_in into lu_data_out (loads only; stores keep previous value), err from ahb_resp_in, go DONE.
REQ-023 ACCESS with ready=0: increment counter; at WAIT_LIMIT-1 without ready -> DONE with err_out=1, request dropped.
REQ-024 DONE: lu_valid_out=1 for exactly one cycle, ms_d_req_out=0, busy_out=0.
REQ-025 Latency: accept at edge N, req high in cycle N+1; ready in cycle N+1 -> lu_valid_out in cycle N+2.
REQ-026 mem_req_in while in ACCESS SHALL be ignored; pipeline holds it under busy_out.
REQ-027 Byte store: data {4{wdata[7:0]}}, mask 4'b0001<<addr[1:0].
REQ-028 Half store: data {2{wdata[15:0]}}, mask 4'b0011<<{addr[1],1'b0}.
REQ-029 Word store (size 10 or 11): data wdata, mask 4'b1111; loads drive mask 4'b0000.
REQ-030 iadder_1_to_0_out, load_size_out, load_unsigned_out SHALL be stable from acceptance through the DONE cycle.

Reset
REQ-031 On rst_in: state IDLE, counter 0, all outputs 0, including lu_data_out.
REQ-032 Reset during ACCESS SHALL deassert ms_d_req_out on the following cycle with no lu_valid_out pulse.

Configuration
REQ-033 Macro MSRV32_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no bus request and goes straight to DONE with err_out=1 and misaligned_out=1 for that cycle.
REQ-034 Macro undefined: misaligned accesses proceed with address aligned down; misaligned_out tied 0.

Structure
REQ-035 Shared package msrv32_pkg SHALL hold FSM state encoding and size codes (SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10).
REQ-036 Store alignment SHALL be one combinational sub-module, msrv32_store_align (size, addr[1:0], wdata -> data, mask).

Verification
REQ-037 Byte store addr 0x1003, wdata 0xAB, ready next cycle -> ms_d_addr_out 0x1000, data 0xABABABAB, mask 1000, valid at N+2, err 0.
REQ-038 Half load addr 0x2002, unsigned 0, rdata 0x8001_1234, ready after 3 wait cycles -> lu_data_out 0x80011234, iadder_1_to_0_out 10, valid at N+5.
REQ-039 Ready never asserted, WAIT_LIMIT=16 -> lu_valid_out with err_out=1 exactly 16 cycles after req rises; req then 0.
REQ-040 ahb_resp_in=1 with ready -> valid with err_out=1; back-to-back second request in DONE -> req high next cycle.
REQ-041 rst_in high in second ACCESS cycle -> req 0 next cycle, no valid pulse, all outputs 0.
REQ-042 With MSRV32_MISALIGN_TRAP_EN, word load addr 0x3001 -> no req, valid+err+misaligned next cycle; without macro -> bus access to 0x3000, misaligned_out 0.
